fgen_ctrl: RTL and testbench

FGEN_CTRL -- requirements
Module: fgen_ctrl

---
 rtl/fgen_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fgen_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fgen_ctrl.sv
// SPI-commanded waveform controller: assembles 32-bit commands from SPI bytes,
// writes waveform samples and plays them back to a DAC at a programmable rate.
module fgen_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 14,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              i_Rst_L,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  input  logic              cs_n,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              dac_enable,
  output logic              busy,
  output logic              cmd_err,
  output logic [7:0]        led
);

  localparam logic [3:0] OP_WRITE   = 4'h1;
  localparam logic [3:0] OP_RUN     = 4'h2;
  localparam logic [3:0] OP_STOP    = 4'h3;
  localparam logic [3:0] OP_SET_DIV = 4'h4;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_PRIME, S_RUN} state_e;

  state_e state, state_nxt;

  logic [1:0]        byte_cnt;
  logic [23:0]       byte_sr;
  logic [31:0]       cmd;
  logic              cmd_valid;
  logic              armed;

  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              err_latch;
  logic              last_write;

  logic              acc_write, acc_run, acc_stop, acc_div, reject;
  logic              accepted, playing;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] wr_addr;
  logic              unused_cmd_bits;

  assign opcode          = cmd[31:28];
  assign wr_addr         = cmd[14+ADDR_W-1:14];
  assign playing         = (state == S_PRIME) || (state == S_RUN);
  assign accepted        = acc_write | acc_run | acc_stop | acc_div;
  assign unused_cmd_bits = ^cmd;

  // Byte assembler. 'armed' stays low after reset until cs_n is seen high, so a
  // frame already in flight when reset releases can never be half-accepted.
  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      byte_cnt  <= '0;
      byte_sr   <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      armed     <= 1'b0;
    end else begin
      // NOTE: registers are updated with <= so every block samples pre-edge values.
      cmd_valid <= 1'b0;
      if (cs_n) begin
        byte_cnt <= '0;
        armed    <= 1'b1;
      end else if (rx_dv && armed) begin
        byte_cnt <= byte_cnt + 2'd1;
        byte_sr  <= {byte_sr[15:0], rx_byte};
        if (byte_cnt == 2'd3) begin
          cmd       <= {byte_sr, rx_byte};
          cmd_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    acc_write = 1'b0;
    acc_run   = 1'b0;
    acc_stop  = 1'b0;
    acc_div   = 1'b0;
    reject    = 1'b0;
    if (state == S_WRITE) state_nxt = S_IDLE;
    if (state == S_PRIME) state_nxt = S_RUN;
    if (cmd_valid) begin
      case (opcode)
        OP_WRITE: begin
          if (playing) reject = 1'b1;
          else begin
            acc_write = 1'b1;
            state_nxt = S_WRITE;
          end
        end
        OP_RUN: begin
          if (!playing) begin
            acc_run   = 1'b1;
            state_nxt = S_PRIME;
          end
        end
        OP_STOP: begin
          if (state != S_IDLE) begin
            acc_stop  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        OP_SET_DIV: begin
          if (playing) reject = 1'b1;
          else         acc_div = 1'b1;
        end
        default: reject = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mem_addr   <= '0;
      mem_din    <= '0;
      div        <= '0;
      div_cnt    <= '0;
      last_addr  <= '0;
      cmd_err    <= 1'b0;
      err_latch  <= 1'b0;
      last_write <= 1'b0;
    end else begin
      cmd_err <= reject;
      if (reject)        err_latch <= 1'b1;
      else if (accepted) err_latch <= 1'b0;
      if (accepted) last_write <= acc_write;
      if (acc_div)  div <= cmd[DIV_W-1:0];

      if (acc_write) begin
        mem_addr <= wr_addr;
        mem_din  <= DATA_W'(cmd[13:0]);
        if (wr_addr > last_addr) last_addr <= wr_addr;
      end else if (acc_run) begin
        mem_addr <= '0;
        div_cnt  <= '0;
      end else if (acc_stop) begin
        mem_addr <= '0;
        if (cmd[0]) last_addr <= '0;
      end else if (state == S_RUN) begin
        // Each sample is held div+1 clocks; the counter restarts on every advance.
        if (div_cnt == div) begin
          div_cnt  <= '0;
          mem_addr <= (mem_addr >= last_addr) ? '0 : mem_addr + ADDR_W'(1);
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign mem_we     = (state == S_WRITE);
  assign dac_enable = (state == S_RUN);
  assign busy       = (state != S_IDLE);

  always_comb begin
    led = 8'd0;
    if (err_latch)       led = 8'd8;
    else if (playing)    led = 8'd2;
    else if (last_write) led = 8'd1;
  end

endmodule

// File: tb/tb_fgen_ctrl.sv
// Self-checking bench for fgen_ctrl: directed scenarios plus randomized command
// streams, compared every cycle against a command-level behavioural model.
module tb_fgen_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 14;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              i_Rst_L;
  logic              rx_dv;
  logic [7:0]        rx_byte;
  logic              cs_n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              dac_enable;
  logic              busy;
  logic              cmd_err;
  logic [7:0]        led;

  fgen_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .i_Rst_L(i_Rst_L), .rx_dv(rx_dv), .rx_byte(rx_byte), .cs_n(cs_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .dac_enable(dac_enable),
    .busy(busy), .cmd_err(cmd_err), .led(led)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int obs_err  = 0;
  int obs_we   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Command-level model: tracks what the user has commanded, and derives the
  // playback address arithmetically from the clocks elapsed since RUN.
  int unsigned edge_n;
  bit          m_armed;
  int          m_nbytes;
  logic [31:0] m_word;
  bit          m_pend;
  logic [31:0] m_pend_cmd;
  bit          m_running;
  int unsigned m_run_edge;
  bit          m_wpulse;
  logic [13:0] m_wdata;
  logic [7:0]  m_idle_addr;
  int unsigned m_div;
  int unsigned m_last;
  bit          m_err_pulse;
  bit          m_err_latch;
  bit          m_last_write;

  task automatic model_reset();
    edge_n = 0; m_armed = 0; m_nbytes = 0; m_word = '0; m_pend = 0; m_pend_cmd = '0;
    m_running = 0; m_run_edge = 0; m_wpulse = 0; m_wdata = '0; m_idle_addr = '0;
    m_div = 0; m_last = 0; m_err_pulse = 0; m_err_latch = 0; m_last_write = 0;
  endtask

  task automatic model_exec(input logic [31:0] c);
    logic [7:0] a;
    a = c[21:14];
    case (c[31:28])
      4'h1: if (m_running) begin m_err_pulse = 1; m_err_latch = 1; end
            else begin
              m_wpulse = 1; m_wdata = c[13:0]; m_idle_addr = a;
              if (a > m_last) m_last = a;
              m_err_latch = 0; m_last_write = 1;
            end
      4'h2: if (!m_running) begin
              m_running = 1; m_run_edge = edge_n; m_err_latch = 0; m_last_write = 0;
            end
      4'h3: if (m_running) begin
              m_running = 0; m_idle_addr = '0;
              if (c[0]) m_last = 0;
              m_err_latch = 0; m_last_write = 0;
            end
      4'h4: if (m_running) begin m_err_pulse = 1; m_err_latch = 1; end
            else begin m_div = c[15:0]; m_err_latch = 0; m_last_write = 0; end
      default: begin m_err_pulse = 1; m_err_latch = 1; end
    endcase
  endtask

  task automatic model_edge(input bit dv, input logic [7:0] b, input bit csn);
    edge_n++;
    m_wpulse = 0;
    m_err_pulse = 0;
    if (m_pend) begin
      model_exec(m_pend_cmd);
      m_pend = 0;
    end
    if (csn) begin
      m_nbytes = 0;
      m_armed = 1;
    end else if (dv && m_armed) begin
      m_word = {m_word[23:0], b};
      m_nbytes++;
      if (m_nbytes == 4) begin
        m_pend = 1; m_pend_cmd = m_word; m_nbytes = 0;
      end
    end
  endtask

  task automatic check_outputs();
    int unsigned k;
    logic [7:0]  e_addr;
    logic        e_dac;
    logic [7:0]  e_led;
    e_dac  = 1'b0;
    e_addr = m_idle_addr;
    if (m_running) begin
      k = edge_n - m_run_edge;
      if (k == 0) e_addr = '0;
      else begin
        e_dac  = 1'b1;
        e_addr = 8'(((k - 1) / (m_div + 1)) % (m_last + 1));
      end
    end
    e_led = m_err_latch ? 8'd8 : m_running ? 8'd2 : m_last_write ? 8'd1 : 8'd0;
    check("mem_we", 32'(mem_we), 32'(m_wpulse));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (m_wpulse) check("mem_din", 32'(mem_din), 32'(m_wdata));
    check("dac_enable", 32'(dac_enable), 32'(e_dac));
    check("busy", 32'(busy), 32'(m_running || m_wpulse));
    check("cmd_err", 32'(cmd_err), 32'(m_err_pulse));
    check("led", 32'(led), 32'(e_led));
    if (cmd_err === 1'b1) obs_err++;
    if (mem_we === 1'b1) obs_we++;
  endtask

  // Entered just after a rising edge: drive, check mid-cycle, take the edge.
  task automatic step(input bit dv, input logic [7:0] b, input bit csn);
    rx_dv = dv; rx_byte = b; cs_n = csn;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    model_edge(dv, b, csn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b1);
  endtask

  task automatic send_frame(input logic [31:0] w, input int max_gap);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, w[8*i +: 8], 1'b0);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step(1'b0, 8'($urandom), 1'b0);
    end
  endtask

  function automatic logic [31:0] wr_cmd(input logic [7:0] a, input logic [13:0] d);
    return {4'h1, 6'(0), a, d};
  endfunction

  // Reset lands between clock edges; outputs must clear without waiting for one.
  task automatic do_reset(input bit csn_during);
    #3;
    i_Rst_L = 1'b0;
    #1;
    check("rst_dac_enable", 32'(dac_enable), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_err", 32'(cmd_err), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    model_reset();
    rx_dv = 1'b0;
    cs_n = csn_during;
    repeat (2) @(posedge clk);
    #1;
    i_Rst_L = 1'b1;
  endtask

  initial begin
    int base_err;
    int base_we;
    logic [31:0] w;
    int sel;

    i_Rst_L = 1'b0; rx_dv = 1'b0; rx_byte = '0; cs_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    i_Rst_L = 1'b1;
    idle(3);

    // Single WRITE: addr 3, data 5.
    base_we = obs_we;
    send_frame(32'h1000_C005, 0);
    idle(4);
    check("write_pulses", 32'(obs_we - base_we), 32'd1);
    check("write_led", 32'(led), 32'd1);

    // Fill 0..3, divide by 3, play.
    for (int a = 0; a < 4; a++) send_frame(wr_cmd(8'(a), 14'(a * 'h111 + 1)), 1);
    send_frame(32'h4000_0002, 0);
    send_frame(32'h2000_0000, 0);
    idle(30);

    // Rejected WRITE and illegal opcode during playback.
    base_err = obs_err;
    send_frame(wr_cmd(8'd1, 14'h3FF), 0);
    send_frame(32'hF000_0000, 0);
    idle(6);
    check("run_err_pulses", 32'(obs_err - base_err), 32'd2);
    check("run_err_led", 32'(led), 32'd8);
    check("run_dac_kept", 32'(dac_enable), 32'd1);

    // Reset mid-run with cs_n low; bytes before a fresh frame must be ignored.
    do_reset(1'b0);
    step(1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0);
    check("no_run_after_reset", 32'(busy), 32'd0);
    idle(2);
    for (int a = 0; a < 3; a++) send_frame(wr_cmd(8'(a), 14'($urandom)), 0);
    send_frame(32'h2000_0000, 0);
    idle(12);
    send_frame(32'h3000_0001, 0);
    idle(3);

    // Aborted partial frame, then an rx_dv coinciding with cs_n high.
    base_we = obs_we;
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h10, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hAB, 1'b1);
    send_frame(32'h1001_4123, 0);
    idle(4);
    check("abort_write_pulses", 32'(obs_we - base_we), 32'd1);

    // Randomized command stream.
    for (int n = 0; n < 90; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: w = wr_cmd(8'($urandom_range(0, 7)), 14'($urandom)) | {4'h0, 6'($urandom), 22'h0};
        3, 4:    w = 32'h2000_0000 | 32'($urandom_range(0, 'hFFFF));
        5, 6:    w = {4'h3, 28'($urandom)};
        7:       w = {4'h4, 12'($urandom), 16'($urandom_range(0, 3))};
        8: begin
          w = {4'h0, 28'($urandom)};
          w[31:28] = 4'($urandom_range(0, 11));
          if (w[31:28] != 4'h0) w[31:28] = w[31:28] + 4'd4;
        end
        default: w = '0;
      endcase
      if (sel == 9) begin
        step(1'b0, 8'h00, 1'b1);
        repeat ($urandom_range(1, 3)) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b1);
      end else begin
        send_frame(w, 2);
      end
      idle($urandom_range(1, 25));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
